// File: rtl/lms_err_monitor.sv
// Sliding-window mean of |e| over the last 2^WIN_LOG2 LMS error samples, with
// hysteresis-based convergence detection for the adaptation control logic.
module lms_err_monitor #(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 10,
  parameter int HOLD_CNT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] e_in,
  input  logic              e_valid,
  input  logic              clear,
  input  logic [DATA_W-2:0] thresh_lo,
  input  logic [DATA_W-2:0] thresh_hi,
  output logic [DATA_W-1:0] mean_out,
  output logic              mean_valid,
  output logic              fill_done,
  output logic              converged
);

  localparam int ABS_W  = DATA_W - 1;
  localparam int SUM_W  = ABS_W + WIN_LOG2;
  localparam int DEPTH  = 2 ** WIN_LOG2;
  localparam int HOLD_W = $clog2(HOLD_CNT + 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CNT - 1);
  localparam logic [WIN_LOG2-1:0] FILL_LAST = {WIN_LOG2{1'b1}};

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_TRACK = 2'd1,
    ST_CONV  = 2'd2
  } state_t;

  // Magnitude of a two's complement sample; the most negative code saturates
  function automatic logic [ABS_W-1:0] abs_sat(input logic [DATA_W-1:0] e);
    logic [DATA_W-1:0] neg;
    neg = ~e + {{(DATA_W-1){1'b0}}, 1'b1};
    if (e == {1'b1, {(DATA_W-1){1'b0}}}) begin
      abs_sat = {ABS_W{1'b1}};
    end else if (e[DATA_W-1]) begin
      abs_sat = neg[ABS_W-1:0];
    end else begin
      abs_sat = e[ABS_W-1:0];
    end
  endfunction

  logic [ABS_W-1:0]    ram_r [DEPTH];
  logic [ABS_W-1:0]    abs_r;
  logic [ABS_W-1:0]    old_r;
  logic [WIN_LOG2-1:0] ptr_r;
  logic [WIN_LOG2-1:0] wr_ptr_r;
  logic                s1_vld_r;
  logic                wr_en_s;

  logic [SUM_W-1:0]    sum_r, sum_s, sum_upd_s, evict_s;
  logic [ABS_W-1:0]    mean_upd_s;
  logic                below_lo_s, above_hi_s;
  logic [HOLD_W-1:0]   hold_r, hold_s;
  logic [WIN_LOG2-1:0] fill_cnt_r, fill_cnt_s;
  state_t              state_r, state_s;
  logic [DATA_W-1:0]   mean_r, mean_s;
  logic                mean_valid_r, mean_valid_s;
  logic                fill_done_r, fill_done_s;
  logic                converged_r, converged_s;

  assign wr_en_s = s1_vld_r & ~clear;

  // Stage 1: capture |e| and its slot, advance the circular write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r <= 1'b0;
      abs_r    <= '0;
      ptr_r    <= '0;
      wr_ptr_r <= '0;
    end else if (clear) begin
      s1_vld_r <= 1'b0;
      wr_ptr_r <= '0;
    end else begin
      s1_vld_r <= e_valid;
      if (e_valid) begin
        abs_r    <= abs_sat(e_in);
        ptr_r    <= wr_ptr_r;
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
    end
  end

  // Window storage: evicted entry read in stage 1, new |e| written in stage 2
  always_ff @(posedge clk) begin
    if (e_valid) begin
      old_r <= ram_r[wr_ptr_r];
    end
    if (wr_en_s) begin
      ram_r[ptr_r] <= abs_r;
    end
  end

  // Stage 2: running sum update, mean and convergence state machine
  always_comb begin
    sum_s        = sum_r;
    state_s      = state_r;
    hold_s       = hold_r;
    fill_cnt_s   = fill_cnt_r;
    mean_s       = mean_r;
    mean_valid_s = 1'b0;
    fill_done_s  = fill_done_r;
    converged_s  = converged_r;

    // While filling, the slot being overwritten holds no valid sample yet
    if (state_r == ST_FILL) begin
      evict_s = '0;
    end else begin
      evict_s = {{WIN_LOG2{1'b0}}, old_r};
    end
    sum_upd_s  = sum_r + {{WIN_LOG2{1'b0}}, abs_r} - evict_s;
    mean_upd_s = sum_upd_s[SUM_W-1:WIN_LOG2];
    below_lo_s = (mean_upd_s < thresh_lo);
    above_hi_s = (mean_upd_s > thresh_hi);

    if (clear) begin
      sum_s        = '0;
      state_s      = ST_FILL;
      hold_s       = '0;
      fill_cnt_s   = '0;
      mean_s       = '0;
      fill_done_s  = 1'b0;
      converged_s  = 1'b0;
    end else if (s1_vld_r) begin
      sum_s = sum_upd_s;
      case (state_r)
        ST_FILL: begin
          if (fill_cnt_r == FILL_LAST) begin
            state_s      = ST_TRACK;
            fill_cnt_s   = '0;
            fill_done_s  = 1'b1;
            mean_valid_s = 1'b1;
            mean_s       = {1'b0, mean_upd_s};
          end else begin
            fill_cnt_s = fill_cnt_r + 1'b1;
          end
        end
        ST_TRACK: begin
          mean_valid_s = 1'b1;
          mean_s       = {1'b0, mean_upd_s};
          if (below_lo_s) begin
            if (hold_r == HOLD_LAST) begin
              state_s     = ST_CONV;
              converged_s = 1'b1;
              hold_s      = '0;
            end else begin
              hold_s = hold_r + 1'b1;
            end
          end else begin
            hold_s = '0;
          end
        end
        ST_CONV: begin
          mean_valid_s = 1'b1;
          mean_s       = {1'b0, mean_upd_s};
          if (above_hi_s) begin
            state_s     = ST_TRACK;
            converged_s = 1'b0;
            hold_s      = '0;
          end else begin
            state_s = ST_CONV;
          end
        end
        default: begin
          state_s     = ST_FILL;
          hold_s      = '0;
          fill_cnt_s  = '0;
          fill_done_s = 1'b0;
          converged_s = 1'b0;
        end
      endcase
    end else begin
      mean_valid_s = 1'b0;
    end
  end

  // Stage 2 state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r        <= '0;
      state_r      <= ST_FILL;
      hold_r       <= '0;
      fill_cnt_r   <= '0;
      mean_r       <= '0;
      mean_valid_r <= 1'b0;
      fill_done_r  <= 1'b0;
      converged_r  <= 1'b0;
    end else begin
      sum_r        <= sum_s;
      state_r      <= state_s;
      hold_r       <= hold_s;
      fill_cnt_r   <= fill_cnt_s;
      mean_r       <= mean_s;
      mean_valid_r <= mean_valid_s;
      fill_done_r  <= fill_done_s;
      converged_r  <= converged_s;
    end
  end

  assign mean_out   = mean_r;
  assign mean_valid = mean_valid_r;
  assign fill_done  = fill_done_r;
  assign converged  = converged_r;

endmodule

// File: tb/tb_lms_err_monitor.sv
// Directed bench for lms_err_monitor (16-sample window, hold count 4).
module tb_lms_err_monitor;

  localparam int DATA_W   = 16;
  localparam int WIN_LOG2 = 4;
  localparam int HOLD_CNT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] e_in = 16'd0;
  logic              e_valid = 1'b0;
  logic              clear = 1'b0;
  logic [DATA_W-2:0] thresh_lo = 15'd50;
  logic [DATA_W-2:0] thresh_hi = 15'd80;
  logic [DATA_W-1:0] mean_out;
  logic              mean_valid;
  logic              fill_done;
  logic              converged;

  lms_err_monitor #(
    .DATA_W  (DATA_W),
    .WIN_LOG2(WIN_LOG2),
    .HOLD_CNT(HOLD_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .e_in      (e_in),
    .e_valid   (e_valid),
    .clear     (clear),
    .thresh_lo (thresh_lo),
    .thresh_hi (thresh_hi),
    .mean_out  (mean_out),
    .mean_valid(mean_valid),
    .fill_done (fill_done),
    .converged (converged)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int mv_cnt = 0;
  int log_mean[$];
  int log_conv[$];

  // Expected (mean, converged) per update: 16 x e=10 into a window of 100, then 3 x e=1000
  int exp_mean[19] = '{94, 88, 83, 77, 71, 66, 60, 55, 49, 43, 38, 32, 26, 21, 15, 10, 71, 133, 195};
  int exp_conv[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};

  // Record every mean update on the falling edge
  always @(negedge clk) begin
    if (mean_valid === 1'b1) begin
      mv_cnt <= mv_cnt + 1;
      log_mean.push_back(int'(mean_out));
      log_conv.push_back(int'(converged));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [DATA_W-1:0] d);
    e_valid = v;
    e_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'hFFFF);
  endtask

  task automatic feed(input logic [DATA_W-1:0] d, input int n, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles && ($urandom_range(0, 1) == 1)) cyc(1'b0, 16'h1234);
      cyc(1'b1, d);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_mean"}, 32'(mean_out), 32'd0);
    check({tag, "_mv"},   32'(mean_valid), 32'd0);
    check({tag, "_fd"},   32'(fill_done), 32'd0);
    check({tag, "_conv"}, 32'(converged), 32'd0);
  endtask

  task automatic check_seq(input string tag, input int base);
    int idx;
    check({tag, "_count"}, 32'(log_mean.size() - base), 32'd19);
    for (int i = 0; i < 19; i++) begin
      idx = base + i;
      check($sformatf("%s_mean%0d", tag, i),
            (idx < log_mean.size()) ? 32'(log_mean[idx]) : 32'hFFFF_FFFF, 32'(exp_mean[i]));
      check($sformatf("%s_conv%0d", tag, i),
            (idx < log_conv.size()) ? 32'(log_conv[idx]) : 32'hFFFF_FFFF, 32'(exp_conv[i]));
    end
  endtask

  int base;
  logic [DATA_W-1:0] d;

  initial begin
    // Power-on reset
    idle(3);
    check_outs_zero("por");
    rst_n = 1'b1;
    idle(2);

    // First fill: output appears two cycles after the 16th sample
    feed(16'd100, 16, 1'b0);
    check("fill_lat_mv", 32'(mean_valid), 32'd0);
    cyc(1'b0, 16'h0000);
    check("fill_mv", 32'(mean_valid), 32'd1);
    check("fill_mean", 32'(mean_out), 32'd100);
    check("fill_fd", 32'(fill_done), 32'd1);
    check("fill_conv", 32'(converged), 32'd0);
    cyc(1'b0, 16'h0000);
    check("fill_pulse", 32'(mean_valid), 32'd0);
    check("fill_hold", 32'(mean_out), 32'd100);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1 check_outs_zero("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = mv_cnt;
    feed(16'd100, 15, 1'b0);
    idle(3);
    check("part_mv_cnt", 32'(mv_cnt - base), 32'd0);
    check("part_fd", 32'(fill_done), 32'd0);
    feed(16'd100, 1, 1'b0);
    idle(2);
    check("refill_mean", 32'(mean_out), 32'd100);
    check("refill_fd", 32'(fill_done), 32'd1);
    check("refill_mv_cnt", 32'(mv_cnt - base), 32'd1);

    // Sign handling and saturation of the most negative code
    for (int i = 0; i < 16; i++) begin
      d = (i % 2 == 0) ? 16'd200 : 16'hFF38;
      cyc(1'b1, d);
    end
    idle(2);
    check("alt_mean", 32'(mean_out), 32'd200);
    cyc(1'b1, 16'h8000);
    idle(2);
    check("sat_mean", 32'(mean_out), 32'd2235);
    check("sat_conv", 32'(converged), 32'd0);

    // Convergence entry and exit, back-to-back
    feed(16'd100, 16, 1'b0);
    idle(2);
    check("b2b_pre_mean", 32'(mean_out), 32'd100);
    base = log_mean.size();
    feed(16'd10, 16, 1'b0);
    feed(16'd1000, 3, 1'b0);
    idle(2);
    check_seq("b2b", base);

    // Same sample sequence with idle bubbles
    feed(16'd100, 16, 1'b1);
    idle(2);
    check("bub_pre_mean", 32'(mean_out), 32'd100);
    check("bub_pre_conv", 32'(converged), 32'd0);
    base = log_mean.size();
    feed(16'd10, 16, 1'b1);
    feed(16'd1000, 3, 1'b1);
    idle(2);
    check_seq("bub", base);

    // clear with a sample in flight and one in the same cycle
    cyc(1'b1, 16'd300);
    clear = 1'b1;
    cyc(1'b1, 16'd5000);
    clear = 1'b0;
    check_outs_zero("clr");
    base = mv_cnt;
    idle(3);
    check("clr_quiet", 32'(mv_cnt - base), 32'd0);
    feed(16'd7, 16, 1'b0);
    idle(2);
    check("clr_mean", 32'(mean_out), 32'd7);
    check("clr_fd", 32'(fill_done), 32'd1);
    check("clr_mv_cnt", 32'(mv_cnt - base), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
